// File: rtl/uart_tx.sv
// UART transmitter: serialises one word per request (start, data LSB first, stop)
// and can also drive a line BREAK. All line-facing outputs are registered.
module uart_tx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 100000000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  output logic                    uart_txd,
  output logic                    uart_tx_busy,
  input  logic                    uart_tx_en,
  input  logic                    uart_tx_break,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CW             = $clog2(CYCLES_PER_BIT) + 1;
  localparam int BREAK_BITS     = 1 + PAYLOAD_BITS + STOP_BITS;
  localparam int BW             = $clog2(BREAK_BITS) + 1;

  localparam logic [CW-1:0] LAST_CYCLE = CW'(CYCLES_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_DATA  = BW'(PAYLOAD_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP  = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0] LAST_BREAK = BW'(BREAK_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [CW-1:0]           r_cycle;
  logic [CW-1:0]           w_cycle_next;
  logic [BW-1:0]           r_bit;
  logic [BW-1:0]           w_bit_next;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic [PAYLOAD_BITS-1:0] w_shift_next;
  logic                    r_txd;
  logic                    w_txd_next;
  logic                    r_busy;
  logic                    w_bit_end;

  assign w_bit_end    = (r_cycle == LAST_CYCLE);
  assign uart_txd     = r_txd;
  assign uart_tx_busy = r_busy;

  always_comb begin
    w_state_next = r_state;
    w_cycle_next = r_cycle + CW'(1);
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_txd_next   = r_txd;

    // The line level is computed alongside the next state so it moves only
    // at bit boundaries and lands in the same register stage as the state.
    case (r_state)
      IDLE: begin
        w_cycle_next = '0;
        w_bit_next   = '0;
        w_txd_next   = 1'b1;
        if (uart_tx_en) begin
          w_txd_next = 1'b0;
          if (uart_tx_break) begin
            w_state_next = BREAK;
          end else begin
            w_state_next = START;
            w_shift_next = uart_tx_data;
          end
        end
      end
      START: begin
        if (w_bit_end) begin
          w_cycle_next = '0;
          w_bit_next   = '0;
          w_state_next = DATA;
          w_txd_next   = r_shift[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_cycle_next = '0;
          w_shift_next = {1'b0, r_shift[PAYLOAD_BITS-1:1]};
          if (r_bit == LAST_DATA) begin
            w_bit_next   = '0;
            w_state_next = STOP;
            w_txd_next   = 1'b1;
          end else begin
            w_bit_next = r_bit + BW'(1);
            w_txd_next = r_shift[1];
          end
        end
      end
      STOP: begin
        w_txd_next = 1'b1;
        if (w_bit_end) begin
          w_cycle_next = '0;
          if (r_bit == LAST_STOP) begin
            w_bit_next   = '0;
            w_state_next = IDLE;
          end else begin
            w_bit_next = r_bit + BW'(1);
          end
        end
      end
      BREAK: begin
        w_txd_next = 1'b0;
        if (w_bit_end) begin
          w_cycle_next = '0;
          if (r_bit == LAST_BREAK) begin
            w_bit_next   = '0;
            w_state_next = STOP;
            w_txd_next   = 1'b1;
          end else begin
            w_bit_next = r_bit + BW'(1);
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cycle_next = '0;
        w_bit_next   = '0;
        w_txd_next   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cycle <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cycle <= w_cycle_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_txd   <= w_txd_next;
      r_busy  <= (w_state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at 10 clocks/bit, 8N1. Stimulus pushes expected line
// patterns; a monitor decodes uart_txd cycle by cycle and checks against them.
module tb_uart_tx;

  localparam int CPB = 10;

  logic       clk;
  logic       resetn;
  logic       uart_txd;
  logic       uart_tx_busy;
  logic       uart_tx_en;
  logic       uart_tx_break;
  logic [7:0] uart_tx_data;

  uart_tx #(
    .BIT_RATE    (100000),
    .CLK_HZ      (1000000),
    .PAYLOAD_BITS(8),
    .STOP_BITS   (1)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .uart_txd     (uart_txd),
    .uart_tx_busy (uart_tx_busy),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_break(uart_tx_break),
    .uart_tx_data (uart_tx_data)
  );

  // pat bit s = line level during bit slot s (time order); slots = slot count
  typedef struct {
    logic [10:0] pat;
    int          slots;
    bit          gap1;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, got, cyc);
    end
  endtask

  task automatic wait_busy(input logic v, input int budget, input string name);
    int n = 0;
    while (uart_tx_busy !== v && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, {31'd0, uart_tx_busy}, {31'd0, v});
  endtask

  task automatic send(input logic [7:0] d, input logic brk, input logic [10:0] pat,
                      input int slots, input bit push, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    uart_tx_data  = d;
    uart_tx_break = brk;
    uart_tx_en    = 1'b1;
    if (push) begin
      e.pat = pat; e.slots = slots; e.gap1 = 1'b0; e.name = name;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    uart_tx_en    = 1'b0;
    uart_tx_break = 1'b0;
    check({name, " latency busy/txd"}, {30'd0, uart_tx_busy, uart_txd}, 32'h2);
  endtask

  // Monitor: a falling txd (outside reset) starts a frame; every cycle of
  // every slot is sampled so short bits, glitches and busy timing all show.
  logic        mon_prev;
  logic [10:0] mon_got;
  bit          mon_glitch, mon_busy_ok, mon_abort;
  int          mon_slots, mon_start, mon_last_end;
  exp_t        mon_e;

  initial begin
    mon_prev     = 1'b1;
    mon_last_end = -1000;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        mon_prev = 1'b1;
      end else if (uart_txd === 1'b0 && mon_prev === 1'b1) begin
        mon_start   = cyc;
        mon_slots   = (sb.size() > 0) ? sb[0].slots : 10;
        mon_got     = '0;
        mon_glitch  = 1'b0;
        mon_busy_ok = 1'b1;
        mon_abort   = 1'b0;
        for (int s = 0; s < mon_slots && !mon_abort; s++) begin
          for (int c = 0; c < CPB && !mon_abort; c++) begin
            if (s != 0 || c != 0) @(negedge clk);
            if (!resetn) begin
              mon_abort = 1'b1;
            end else begin
              if (c == 0) mon_got[s] = uart_txd;
              else if (uart_txd !== mon_got[s]) mon_glitch = 1'b1;
              if (uart_tx_busy !== 1'b1) mon_busy_ok = 1'b0;
            end
          end
        end
        if (!mon_abort) begin
          @(negedge clk);
          if (!resetn) mon_abort = 1'b1;
          else if (uart_tx_busy !== 1'b0 || uart_txd !== 1'b1) mon_busy_ok = 1'b0;
        end
        if (mon_abort) begin
          $display("note monitor: frame abandoned by reset at cycle %0d", cyc);
          mon_prev = 1'b1;
        end else if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected frame: got pattern=%0h at cycle %0d, want no frame", mon_got, mon_start);
          mon_prev     = uart_txd;
          mon_last_end = cyc;
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, " line pattern"}, {21'd0, mon_got}, {21'd0, mon_e.pat});
          check({mon_e.name, " bit glitch"}, {31'd0, mon_glitch}, 32'd0);
          check({mon_e.name, " busy span"}, {31'd0, mon_busy_ok}, 32'd1);
          if (mon_e.gap1)
            check({mon_e.name, " idle gap"}, mon_start - mon_last_end, 32'd1);
          mon_prev     = uart_txd;
          mon_last_end = cyc;
        end
      end else begin
        mon_prev = uart_txd;
      end
    end
  end

  initial begin
    exp_t e;
    resetn        = 1'b0;
    uart_tx_en    = 1'b0;
    uart_tx_break = 1'b0;
    uart_tx_data  = 8'h00;

    // 1: reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("in reset txd/busy", {30'd0, uart_txd, uart_tx_busy}, 32'h2);
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (i % 5 == 0) check("idle txd/busy", {30'd0, uart_txd, uart_tx_busy}, 32'h2);
    end

    // 2: single frame 0xA5 -> 0,1,0,1,0,0,1,0,1,1
    send(8'hA5, 1'b0, 11'h34A, 10, 1'b1, "frame A5");
    wait_busy(1'b0, 200, "A5 busy falls");
    repeat (5) @(posedge clk);

    // 3: en held, 0x00 then 0xFF sampled at the second accept
    @(posedge clk);
    #1;
    e.pat = 11'h200; e.slots = 10; e.gap1 = 1'b0; e.name = "held 00";
    sb.push_back(e);
    uart_tx_data = 8'h00;
    uart_tx_en   = 1'b1;
    wait_busy(1'b1, 5, "held 00 busy rises");
    uart_tx_data = 8'hFF;
    e.pat = 11'h3FE; e.slots = 10; e.gap1 = 1'b1; e.name = "held FF";
    sb.push_back(e);
    wait_busy(1'b0, 200, "held 00 busy falls");
    wait_busy(1'b1, 5, "held FF busy rises");
    uart_tx_en = 1'b0;
    wait_busy(1'b0, 200, "held FF busy falls");
    repeat (5) @(posedge clk);

    // 4: request mid-frame is ignored and not queued
    send(8'h81, 1'b0, 11'h302, 10, 1'b1, "frame 81");
    repeat (40) @(posedge clk);
    #1;
    uart_tx_data = 8'h7E;
    uart_tx_en   = 1'b1;
    @(posedge clk);
    #1;
    uart_tx_en = 1'b0;
    wait_busy(1'b0, 200, "81 busy falls");
    repeat (30) @(posedge clk);
    #1;
    check("no queued frame busy", {31'd0, uart_tx_busy}, 32'd0);

    // 5: break -> 100 low cycles, 10 high, 110 busy
    send(8'h55, 1'b1, 11'h400, 11, 1'b1, "break");
    wait_busy(1'b0, 300, "break busy falls");
    repeat (5) @(posedge clk);

    // 6: async reset at cycle ~35 of a frame, then a clean 0x3C frame
    send(8'hC3, 1'b0, 11'h000, 10, 1'b0, "aborted C3");
    repeat (34) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("async reset txd/busy", {30'd0, uart_txd, uart_tx_busy}, 32'h2);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    send(8'h3C, 1'b0, 11'h278, 10, 1'b1, "frame 3C");
    wait_busy(1'b0, 200, "3C busy falls");

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard drained", sb.size(), 32'd0);
    check("final idle txd/busy", {30'd0, uart_txd, uart_tx_busy}, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
